// File: rtl/mult_pkg.sv
// Types and widths shared by the serial multiplier and its downstream consumers.
package mult_pkg;

  localparam int unsigned PROD_W = 32;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} macc_state_e;

  typedef logic [PROD_W-1:0] prod_t;

endpackage

// File: rtl/mult_accumulator.sv
// Sums a programmed number of multiplier products and hands the total out on a valid/ready port.
// Every output is a flop; drop flags strobes that arrive outside ACCUM.
module mult_accumulator
  import mult_pkg::*;
#(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  prod_t            c,
  input  logic             result_vld,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_vld,
  input  logic             acc_rdy,
  output logic             busy,
  output logic             overflow,
  output logic             drop
);

  localparam logic [LEN_W-1:0] CntOne = LEN_W'(1);

  macc_state_e      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;

  // One extra bit catches the carry out of the accumulator.
  logic [ACC_W:0]   sum;
  assign sum = {1'b0, acc_q} + {{(ACC_W - PROD_W + 1){1'b0}}, c};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    drop_d  = result_vld && (state_q != ACCUM);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            len_d   = len;
            state_d = ACCUM;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACCUM: begin
        if (result_vld) begin
          acc_d = sum[ACC_W-1:0];
          cnt_d = cnt_q + CntOne;
          if (sum[ACC_W]) ovf_d = 1'b1;
          if (cnt_d == len_q) state_d = DONE;
        end
      end
      DONE: begin
        if (acc_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    vld_d  = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign acc_out  = acc_q;
  assign acc_vld  = vld_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign drop     = drop_q;

endmodule

// File: doc/mult_accumulator.md
Name: mult_accumulator

Overview:
Downstream consumer of the serial multiplier (`two_bit_multiplier2`, 16-bit `a` × N-bit `b`, 32-bit `c`).
- Sums a programmed number of consecutive products (`c` qualified by `result_vld`) into a wide accumulator.
- Presents the final sum on a valid/ready output.
- Builds dot-product and MAC operations from the existing multiplier without touching it.

Parameters:
- PROD_W, 32, width of the incoming product `c`.
- ACC_W, 40, accumulator and output width; must be ≥ PROD_W.
- LEN_W, 8, width of the product-count field; 1 to 2^LEN_W−1 products per run.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle request to begin a run; honoured only in IDLE.
- len  input  LEN_W  number of products to accumulate; sampled when `start` is honoured.
- c  input  PROD_W  product from the multiplier, unsigned.
- result_vld  input  1  one-cycle strobe marking `c` valid.
- acc_out  output  ACC_W  final sum; stable while `acc_vld` is high.
- acc_vld  output  1  result available.
- acc_rdy  input  1  consumer accepts the result.
- busy  output  1  high in ACCUM and DONE.
- overflow  output  1  sticky per run; set if any addition carries out of ACC_W.
- drop  output  1  one-cycle pulse when `result_vld` arrives outside ACCUM.

Behaviour:
- Reset: when `rst_n` = 0 at a clock edge, the next state is:
  - state = IDLE;
  - `acc_out` = 0, `acc_vld` = 0, `busy` = 0, `overflow` = 0, `drop` = 0;
  - internal count = 0, latched length = 0.
- Reset mid-run abandons the run with no output.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - `start` = 1 with `len` ≠ 0: latch `len`, clear accumulator, count and `overflow`; go to ACCUM next cycle.
  - `start` = 1 with `len` = 0: clear accumulator and `overflow`; go directly to DONE, so `acc_out` = 0 and `acc_vld` = 1 the next cycle.
- ACCUM:
  - Each cycle with `result_vld` = 1: acc ← acc + zero-extend(`c`); count ← count + 1.
  - Carry out of bit ACC_W−1 sets `overflow`; the accumulator wraps modulo 2^ACC_W.
  - When the increment makes count equal the latched length, go to DONE.
  - Latency: the last strobe is at cycle t; `acc_vld` = 1 at t+1 and `acc_out` includes that last product.
  - No backpressure to the multiplier; every strobe in ACCUM is consumed.
- DONE:
  - `acc_vld` = 1 and `acc_out` held constant until `acc_rdy` = 1.
  - On the handshake cycle, `acc_vld` = 0 the next cycle and state returns to IDLE.
  - `acc_out` keeps its last value in IDLE; `overflow` holds until the next honoured `start`.
- `start` while `busy` = 1 is ignored, with no queueing.
- `start` in the same cycle as the DONE handshake is also ignored; a new run needs `start` in IDLE.
- `result_vld` in IDLE or DONE:
  - the product is discarded;
  - `drop` = 1 the following cycle;
  - accumulator and count are unchanged.
- `result_vld` in the same cycle as the honoured `start` (IDLE): dropped, per the rule above.
- `busy` = 1 whenever state ≠ IDLE; it is a registered output.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package `mult_pkg` holds:
  - `localparam PROD_W = 32`;
  - `typedef enum logic [1:0] {IDLE, ACCUM, DONE} macc_state_e`;
  - `typedef logic [PROD_W-1:0] prod_t`.
- The multiplier bench and this block both import it.
- No sub-module; the ACC_W-wide adder with carry-out is a single expression.
- Integration: a top-level `mult_mac` instantiating `two_bit_multiplier2` plus this block is a separate follow-on.

Test Plan:
1. Reset, `start` with `len` = 3, strobes `c` = 10, 20, 30 on non-adjacent cycles -> `acc_out` = 60, `acc_vld` = 1 exactly one cycle after the third strobe, `overflow` = 0.
2. `len` = 2, back-to-back strobes `c` = 0xFFFF_FFFF twice with ACC_W = 32 -> `acc_out` = 0xFFFF_FFFE, `overflow` = 1. Next run `len` = 1, `c` = 5 -> `acc_out` = 5, `overflow` = 0.
3. `start` with `len` = 0 -> `acc_vld` = 1, `acc_out` = 0 next cycle. Hold `acc_rdy` = 0 for 5 cycles -> `acc_out` stable throughout; `acc_rdy` = 1 -> IDLE and `busy` = 0 next cycle.
4. Strobe `c` = 7 in IDLE -> `drop` pulses one cycle, then a `len` = 1 run with `c` = 9 -> `acc_out` = 9.
5. Mid-ACCUM (`len` = 4, 2 strobes done): assert `start` -> ignored. Then drive `rst_n` = 0 for one cycle -> all outputs 0, IDLE. Fresh `len` = 1 run with `c` = 3 -> `acc_out` = 3.
6. End-to-end with the multiplier (N = 4): products 1234×3, 500×5, 65535×15 with `len` = 3 -> `acc_out` = 3702 + 2500 + 983025 = 989227.
